// File: rtl/seq_playback_ctrl.sv
// Sequence playback scheduler: walks BRAM words (pattern + hold duration), applies two loop
// descriptors and prefetches the successor word so consecutive segments abut with no gap cycle.
module seq_playback_ctrl #(
   parameter int               ADDR_W   = 12,
   parameter int               PAT_W    = 8,
   parameter int               TIM_W    = 40,
   parameter logic [PAT_W-1:0] IDLE_PAT = 8'h00
) (
   input  logic                     CLK,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic [ADDR_W-1:0]        seq_len,
   input  logic [ADDR_W-1:0]        lstr0,
   input  logic [ADDR_W-1:0]        lend0,
   input  logic [15:0]              lnum0,
   input  logic [ADDR_W-1:0]        lstr1,
   input  logic [ADDR_W-1:0]        lend1,
   input  logic [15:0]              lnum1,
   output logic [ADDR_W-1:0]        bram_addr,
   input  logic [PAT_W+TIM_W-1:0]   bram_dout,
   output logic [PAT_W-1:0]         pattern,
   output logic                     busy,
   output logic                     done
);

   localparam int                WORD_W    = PAT_W + TIM_W;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [TIM_W-1:0]  TIM_ZERO  = {TIM_W{1'b0}};
   localparam logic [TIM_W-1:0]  TIM_ONE   = {{(TIM_W-1){1'b0}}, 1'b1};
   localparam logic [TIM_W-1:0]  TIM_TWO   = {{(TIM_W-2){1'b0}}, 2'b10};
   localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   bram_addr_r;
   logic [PAT_W-1:0]    pattern_r;
   logic                busy_r;
   logic                done_r;
   logic [TIM_W-1:0]    hold_cnt_r;
   logic [WORD_W-1:0]   next_word_r;
   logic [1:0]          fetch_ph_r;
   logic                last_r;
   logic [15:0]         cnt0_r;
   logic [15:0]         cnt1_r;
   logic [ADDR_W-1:0]   seq_len_r;
   logic [ADDR_W-1:0]   lstr0_r;
   logic [ADDR_W-1:0]   lend0_r;
   logic [15:0]         lnum0_r;
   logic [ADDR_W-1:0]   lstr1_r;
   logic [ADDR_W-1:0]   lend1_r;
   logic [15:0]         lnum1_r;

   logic [WORD_W-1:0]   word_s;
   logic [TIM_W-1:0]    dur_s;
   logic [TIM_W-1:0]    seg_len_s;
   logic                load_s;
   logic                jump0_s;
   logic                jump1_s;
   logic [ADDR_W-1:0]   nxt_addr_s;
   logic [15:0]         nxt_cnt0_s;
   logic [15:0]         nxt_cnt1_s;
   logic                last_s;

   assign bram_addr = bram_addr_r;
   assign pattern   = pattern_r;
   assign busy      = busy_r;
   assign done      = done_r;

   // Word to load and its clamped hold length; a 2-cycle hold has not captured yet, so bypass.
   always_comb begin
      word_s    = WORD_ZERO;
      dur_s     = TIM_ZERO;
      seg_len_s = TIM_TWO;
      load_s    = 1'b0;
      if (fetch_ph_r == 2'd2) begin
         word_s = next_word_r;
      end else begin
         word_s = bram_dout;
      end
      dur_s = word_s[TIM_W-1:0];
      if (dur_s < TIM_TWO) begin
         seg_len_s = TIM_TWO;
      end else begin
         seg_len_s = dur_s;
      end
      load_s = ((state_r == PRIME) && (fetch_ph_r == 2'd2)) ||
               ((state_r == HOLD) && (hold_cnt_r == TIM_ONE) && !last_r);
   end

   // Successor of the segment being entered; bram_addr_r holds that segment's address here.
   always_comb begin
      jump0_s    = (bram_addr_r == lend0_r) && (lstr0_r <= lend0_r) && (cnt0_r < lnum0_r);
      jump1_s    = (bram_addr_r == lend1_r) && (lstr1_r <= lend1_r) && (cnt1_r < lnum1_r);
      nxt_addr_s = bram_addr_r + ADDR_ONE;
      nxt_cnt0_s = cnt0_r;
      nxt_cnt1_s = cnt1_r;
      last_s     = 1'b0;
      if (jump0_s) begin
         nxt_addr_s = lstr0_r;
         nxt_cnt0_s = cnt0_r + 16'd1;
      end else begin
         if (bram_addr_r == lend0_r) begin
            nxt_cnt0_s = 16'd0;
         end else begin
            nxt_cnt0_s = cnt0_r;
         end
         if (jump1_s) begin
            nxt_addr_s = lstr1_r;
            nxt_cnt1_s = cnt1_r + 16'd1;
         end else begin
            if (bram_addr_r == lend1_r) begin
               nxt_cnt1_s = 16'd0;
            end else begin
               nxt_cnt1_s = cnt1_r;
            end
            last_s = (bram_addr_r == seq_len_r);
         end
      end
   end

   // Playback FSM with registered outputs; stop overrides everything, done only on natural end.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         bram_addr_r <= ADDR_ZERO;
         pattern_r   <= IDLE_PAT;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         hold_cnt_r  <= TIM_ZERO;
         next_word_r <= WORD_ZERO;
         fetch_ph_r  <= 2'd0;
         last_r      <= 1'b0;
         cnt0_r      <= 16'd0;
         cnt1_r      <= 16'd0;
         seq_len_r   <= ADDR_ZERO;
         lstr0_r     <= ADDR_ZERO;
         lend0_r     <= ADDR_ZERO;
         lnum0_r     <= 16'd0;
         lstr1_r     <= ADDR_ZERO;
         lend1_r     <= ADDR_ZERO;
         lnum1_r     <= 16'd0;
      end else begin
         done_r <= 1'b0;
         if (fetch_ph_r == 2'd1) begin
            next_word_r <= bram_dout;
         end
         if (fetch_ph_r != 2'd2) begin
            fetch_ph_r <= fetch_ph_r + 2'd1;
         end
         if (stop) begin
            state_r     <= IDLE;
            pattern_r   <= IDLE_PAT;
            busy_r      <= 1'b0;
            bram_addr_r <= ADDR_ZERO;
            fetch_ph_r  <= 2'd2;
         end else if (load_s) begin
            state_r     <= HOLD;
            pattern_r   <= word_s[WORD_W-1:TIM_W];
            hold_cnt_r  <= seg_len_s;
            bram_addr_r <= nxt_addr_s;
            cnt0_r      <= nxt_cnt0_s;
            cnt1_r      <= nxt_cnt1_s;
            last_r      <= last_s;
            fetch_ph_r  <= 2'd0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (start) begin
                     seq_len_r   <= seq_len;
                     lstr0_r     <= lstr0;
                     lend0_r     <= lend0;
                     lnum0_r     <= lnum0;
                     lstr1_r     <= lstr1;
                     lend1_r     <= lend1;
                     lnum1_r     <= lnum1;
                     cnt0_r      <= 16'd0;
                     cnt1_r      <= 16'd0;
                     last_r      <= 1'b0;
                     bram_addr_r <= ADDR_ZERO;
                     busy_r      <= 1'b1;
                     fetch_ph_r  <= 2'd0;
                     state_r     <= PRIME;
                  end
               end
               PRIME: begin
                  state_r <= PRIME;
               end
               HOLD: begin
                  if (hold_cnt_r == TIM_ONE) begin
                     state_r     <= IDLE;
                     pattern_r   <= IDLE_PAT;
                     busy_r      <= 1'b0;
                     done_r      <= 1'b1;
                     bram_addr_r <= ADDR_ZERO;
                     fetch_ph_r  <= 2'd2;
                  end else begin
                     hold_cnt_r <= hold_cnt_r - TIM_ONE;
                  end
               end
               default: begin
                  state_r   <= IDLE;
                  pattern_r <= IDLE_PAT;
                  busy_r    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// Directed bench for seq_playback_ctrl: a registered-read BRAM model plus hand-computed
// per-cycle pattern/busy/done expectations for each scenario.
module tb_seq_playback_ctrl;

   logic        CLK = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [11:0] seq_len = 12'd0;
   logic [11:0] lstr0 = 12'd1;
   logic [11:0] lend0 = 12'd0;
   logic [15:0] lnum0 = 16'd0;
   logic [11:0] lstr1 = 12'd1;
   logic [11:0] lend1 = 12'd0;
   logic [15:0] lnum1 = 16'd0;
   logic [11:0] bram_addr;
   logic [47:0] bram_dout = 48'd0;
   logic [7:0]  pattern;
   logic        busy;
   logic        done;

   logic [47:0] mem [0:15];
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  seg_pat [$];
   int          seg_dur [$];

   seq_playback_ctrl dut (
      .CLK(CLK), .rst(rst), .start(start), .stop(stop), .seq_len(seq_len),
      .lstr0(lstr0), .lend0(lend0), .lnum0(lnum0),
      .lstr1(lstr1), .lend1(lend1), .lnum1(lnum1),
      .bram_addr(bram_addr), .bram_dout(bram_dout),
      .pattern(pattern), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) bram_dout <= mem[bram_addr[3:0]];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Starts playback and checks every cycle against seg_pat/seg_dur (effective hold lengths).
   // At cycle mid_k a stray start pulse and a new seq_len are applied; both must be ignored.
   task automatic play_check(input string tag, input int mid_k);
      logic [7:0] exp_q [$];
      exp_q = {8'h00, 8'h00};
      foreach (seg_pat[i])
         for (int j = 0; j < seg_dur[i]; j++) exp_q.push_back(seg_pat[i]);
      do_start();
      for (int k = 1; k <= exp_q.size(); k++) begin
         if (k == mid_k) begin
            start   = 1'b1;
            seq_len = 12'd7;
         end
         @(negedge CLK);
         start = 1'b0;
         chk($sformatf("%s_pat_k%0d", tag, k), {56'd0, pattern}, {56'd0, exp_q[k-1]});
         chk($sformatf("%s_busy_k%0d", tag, k), {63'd0, busy}, 64'd1);
         chk($sformatf("%s_done_k%0d", tag, k), {63'd0, done}, 64'd0);
      end
      @(negedge CLK);
      chk({tag, "_end_pat"}, {56'd0, pattern}, 64'd0);
      chk({tag, "_end_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_end_done"}, {63'd0, done}, 64'd1);
      chk({tag, "_end_addr"}, {52'd0, bram_addr}, 64'd0);
      @(negedge CLK);
      chk({tag, "_post_done"}, {63'd0, done}, 64'd0);
      chk({tag, "_post_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 48'd0;
      repeat (2) @(negedge CLK);
      chk("rst_pat", {56'd0, pattern}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_addr", {52'd0, bram_addr}, 64'd0);
      rst = 1'b0;
      @(negedge CLK);

      // Two words, no loops
      mem[0] = {8'hA5, 40'd5};
      mem[1] = {8'h3C, 40'd3};
      seq_len = 12'd1;
      seg_pat = '{8'hA5, 8'h3C};
      seg_dur = '{5, 3};
      play_check("basic", 0);

      // Duration 0 clamps to 2
      mem[0] = {8'hA5, 40'd0};
      seg_dur = '{2, 3};
      play_check("clamp", 0);

      // Loop 0 over 1..2 with two extra passes
      mem[0] = {8'h11, 40'd2};
      mem[1] = {8'h22, 40'd2};
      mem[2] = {8'h33, 40'd2};
      mem[3] = {8'h44, 40'd2};
      seq_len = 12'd3;
      lstr0 = 12'd1; lend0 = 12'd2; lnum0 = 16'd2;
      seg_pat = '{8'h11, 8'h22, 8'h33, 8'h22, 8'h33, 8'h22, 8'h33, 8'h44};
      seg_dur = '{2, 2, 2, 2, 2, 2, 2, 2};
      play_check("loop0", 0);

      // Nested loops: loop 0 re-arms on the outer pass
      mem[0] = {8'h11, 40'd3};
      mem[1] = {8'h22, 40'd1};
      mem[3] = {8'h44, 40'd4};
      lnum0 = 16'd1;
      lstr1 = 12'd0; lend1 = 12'd3; lnum1 = 16'd1;
      seg_pat = '{8'h11, 8'h22, 8'h33, 8'h22, 8'h33, 8'h44,
                  8'h11, 8'h22, 8'h33, 8'h22, 8'h33, 8'h44};
      seg_dur = '{3, 2, 2, 2, 2, 4, 3, 2, 2, 2, 2, 4};
      play_check("nested", 0);

      // Stop during word 1 of the two-word sequence
      mem[0] = {8'hA5, 40'd5};
      mem[1] = {8'h3C, 40'd3};
      seq_len = 12'd1;
      lstr0 = 12'd1; lend0 = 12'd0; lnum0 = 16'd0;
      lstr1 = 12'd1; lend1 = 12'd0; lnum1 = 16'd0;
      do_start();
      repeat (9) @(negedge CLK);
      chk("stop_pre_pat", {56'd0, pattern}, 64'h3C);
      stop = 1'b1;
      @(negedge CLK);
      stop = 1'b0;
      chk("stop_pat", {56'd0, pattern}, 64'd0);
      chk("stop_busy", {63'd0, busy}, 64'd0);
      chk("stop_done", {63'd0, done}, 64'd0);
      repeat (2) @(negedge CLK);
      chk("stop_late_done", {63'd0, done}, 64'd0);
      chk("stop_late_busy", {63'd0, busy}, 64'd0);

      // Replay from 0; stray start and seq_len change mid-run are ignored
      seg_pat = '{8'hA5, 8'h3C};
      seg_dur = '{5, 3};
      play_check("replay", 5);
      seq_len = 12'd1;

      // start and stop together in IDLE
      start = 1'b1;
      stop  = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_busy", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge CLK);
      chk("ss_busy_late", {63'd0, busy}, 64'd0);
      chk("ss_pat_late", {56'd0, pattern}, 64'd0);

      // Asynchronous reset between clock edges mid-playback
      do_start();
      repeat (4) @(negedge CLK);
      chk("arst_pre_pat", {56'd0, pattern}, 64'hA5);
      #2 rst = 1'b1;
      #1;
      chk("arst_pat", {56'd0, pattern}, 64'd0);
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_addr", {52'd0, bram_addr}, 64'd0);
      #1 rst = 1'b0;
      repeat (3) @(negedge CLK);
      chk("arst_idle_busy", {63'd0, busy}, 64'd0);
      chk("arst_idle_done", {63'd0, done}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_playback_ctrl.md
Name: seq_playback_ctrl

Overview:
- Playback scheduler for the 48-bit sequence BRAM (one word = 8-bit output pattern in [47:40] + 40-bit hold duration in [39:0]).
- Owns the BRAM read address while playing. Walks addresses 0..seq_len, holding each pattern for its duration in clock cycles.
- Supports two loop descriptors, and prefetches the next word so successive segments have no gap cycles.
- Sits between the UART command/write logic, which supplies the configuration plus start/stop strobes, and the LED/output pins.

Parameters:
ADDR_W, 12, BRAM address width
PAT_W, 8, output pattern width
TIM_W, 40, duration field width
IDLE_PAT, 8'h00, pattern driven when not playing

Ports:
CLK  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle strobe; begins playback from address 0
stop  in  1  one-cycle strobe; aborts playback
seq_len  in  ADDR_W  last address to play (inclusive)
lstr0  in  ADDR_W  loop 0 start address
lend0  in  ADDR_W  loop 0 end address
lnum0  in  16  loop 0 extra repeat count
lstr1  in  ADDR_W  loop 1 start address
lend1  in  ADDR_W  loop 1 end address
lnum1  in  16  loop 1 extra repeat count
bram_addr  out  ADDR_W  BRAM read address
bram_dout  in  48  BRAM read data, valid 1 cycle after bram_addr
pattern  out  PAT_W  registered output pattern
busy  out  1  high from start accept until return to IDLE
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset values: pattern=IDLE_PAT, bram_addr=0, busy=0, done=0, state=IDLE, all counters and shadows 0.
- Config shadowing: seq_len, lstr*, lend*, lnum* are latched on start acceptance. Input changes during playback have no effect.
- States: IDLE, PRIME, HOLD.
- IDLE:
  - start=1 → latch config, bram_addr=0, loop counters=0, busy=1, go to PRIME.
  - start while busy is ignored.
- PRIME (2 cycles):
  - Cycle 1: address 0 settles.
  - Cycle 2: capture bram_dout into the next-word register.
  - Then load pattern/duration from next-word and enter HOLD.
  - Latency: start high at edge T → pattern = word0 after edge T+3.
- Duration:
  - Effective hold D = max(dur, 2) cycles; dur=0 or 1 is clamped to 2.
  - Duration counter width is TIM_W.
- HOLD:
  - At segment entry, compute the successor address and drive it on bram_addr.
  - Capture bram_dout into next-word one cycle later.
  - After D cycles, pattern takes the next-word pattern on the following edge, with no idle cycle between segments.
- Successor of current address a (evaluated once per segment, at segment entry):
  - If a==lend0, lstr0<=lend0, and cnt0<lnum0 → next=lstr0, cnt0+1.
  - Else if a==lend0 → cnt0=0, then continue with the loop-1 and default rules.
  - Loop 1 uses the identical rule with lend1/lstr1/cnt1/lnum1.
  - Loop 0 has priority when lend0==lend1.
  - Otherwise next=a+1.
  - lstr>lend disables that loop. lnum=0 means the body plays exactly once.
- Termination:
  - When the segment at address seq_len expires and no loop jump applies, pattern=IDLE_PAT, busy=0, done=1 for one cycle, bram_addr=0, state=IDLE.
  - seq_len=0 plays word 0 only.
- Address arithmetic wraps modulo 2^ADDR_W. Reaching seq_len is always checked before wrap.
- Stop:
  - Any state, stop=1 → next edge: IDLE, pattern=IDLE_PAT, busy=0, done NOT asserted.
  - stop and start together in IDLE: stop wins, nothing starts.
- Reset mid-operation: immediate return to reset values, independent of the clock.

Test Plan:
- Words {0:(8'hA5,5), 1:(8'h3C,3)}, seq_len=1, loops disabled, start at T → pattern A5 during T+3..T+7, 3C during T+8..T+10, IDLE_PAT and done pulse at T+11, busy falls with done.
- Same contents with word0 dur=0 → A5 held exactly 2 cycles (clamp), then 3C for 3 cycles.
- Words 0..3 with dur=2 each, loop0 lstr=1, lend=2, lnum=2, seq_len=3 → address order 0,1,2,1,2,1,2,3, then done; total 16 pattern cycles.
- Loop0 {1..2, lnum=1} plus loop1 {0..3, lnum=1}, seq_len=3 → order 0,1,2,1,2,3,0,1,2,1,2,3, then done; cnt0 re-arms on the second pass.
- stop asserted mid-HOLD of word 1 → pattern=IDLE_PAT, busy=0 next edge, no done. A start afterwards replays from address 0; a start pulse during busy is ignored.
- Async rst pulse between clock edges during playback → pattern=IDLE_PAT and busy=0 before the next edge; changing seq_len mid-run does not change the end point.
